// File: rtl/ultrasonic_pkg.sv
// Shared constants, state encoding and sizing helpers for the ultrasonic scan sequencer.
package ultrasonic_pkg;

  localparam int NUM_SENSORS = 8;
  localparam int SEL_W       = 3;

  localparam int DEF_TRIG_CYCLES    = 1000;
  localparam int DEF_TIMEOUT_CYCLES = 3_000_000;
  localparam int DEF_GUARD_CYCLES   = 6_000_000;
  localparam int DEF_CNT_W          = 22;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_GUARD     = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    TRIG      = ST_TRIG,
    WAIT_RISE = ST_WAIT_RISE,
    MEASURE   = ST_MEASURE,
    GUARD     = ST_GUARD
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width of the single shared phase counter: must reach the largest cycle count.
  function automatic int ctr_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c) + 1);
  endfunction

endpackage

// File: rtl/ultrasonic_scan_sequencer_if.sv
// Sensor-array side bundle: enable/echo inputs, decoder select, trigger and result outputs.
interface ultrasonic_scan_sequencer_if
  import ultrasonic_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) ();

  logic                   enable;
  logic [NUM_SENSORS-1:0] echo;
  logic [SEL_W-1:0]       sensor_sel;
  logic                   trig;
  logic                   result_valid;
  logic [SEL_W-1:0]       result_idx;
  logic [CNT_W-1:0]       result_count;
  logic                   result_timeout;
  logic                   scan_done;

  modport master (
    input  enable, echo,
    output sensor_sel, trig, result_valid, result_idx, result_count, result_timeout, scan_done
  );

  modport slave (
    output enable, echo,
    input  sensor_sel, trig, result_valid, result_idx, result_count, result_timeout, scan_done
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, parameterized width.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments so both flops sample the pre-edge values and form a true two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/ultrasonic_scan_sequencer.sv
// Round-robin trigger/echo-width sequencer for the eight-channel ultrasonic array.
module ultrasonic_scan_sequencer
  import ultrasonic_pkg::*;
#(
  parameter int TRIG_CYCLES    = DEF_TRIG_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int GUARD_CYCLES   = DEF_GUARD_CYCLES,
  parameter int CNT_W          = DEF_CNT_W
) (
  input logic                         clk,
  input logic                         reset,
  ultrasonic_scan_sequencer_if.master bus
);

  localparam int CTR_W = ctr_width(TRIG_CYCLES, TIMEOUT_CYCLES, GUARD_CYCLES);

  localparam logic [CTR_W-1:0] CTR_ONE      = CTR_W'(1);
  localparam logic [CTR_W-1:0] TRIG_LAST    = CTR_W'(TRIG_CYCLES - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LAST = CTR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CTR_W-1:0] TIMEOUT_LIM  = CTR_W'(TIMEOUT_CYCLES);
  localparam logic [CTR_W-1:0] GUARD_LAST   = CTR_W'(GUARD_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_ONE      = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_LAST     = SEL_W'(NUM_SENSORS - 1);

  logic [NUM_SENSORS-1:0] echo_sync;
  logic                   echo_sel;

  state_e           state_q, state_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             trig_q;

  logic             res_valid_q, res_valid_d;
  logic [SEL_W-1:0] res_idx_q;
  logic [CNT_W-1:0] res_count_q, res_count_d;
  logic             res_timeout_q, res_timeout_d;
  logic             scan_done_q;

  sync_2ff #(.WIDTH(NUM_SENSORS)) u_echo_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.echo),
    .q_o   (echo_sync)
  );

  assign echo_sel = echo_sync[sel_q];

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can leave a latch behind.
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    res_valid_d   = 1'b0;
    res_count_d   = res_count_q;
    res_timeout_d = res_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (bus.enable) begin
          state_d = TRIG;
          cnt_d   = '0;
        end
      end

      TRIG: begin
        if (cnt_q == TRIG_LAST) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end

      // The rise cycle itself is the first counted high cycle of the echo.
      WAIT_RISE: begin
        if (echo_sel) begin
          state_d = MEASURE;
          cnt_d   = CTR_ONE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          res_valid_d   = 1'b1;
          res_count_d   = '1;
          res_timeout_d = 1'b1;
          state_d       = GUARD;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end

      MEASURE: begin
        if (!echo_sel) begin
          res_valid_d   = 1'b1;
          res_count_d   = CNT_W'(cnt_q);
          res_timeout_d = 1'b0;
          state_d       = GUARD;
          cnt_d         = '0;
        end else if (cnt_q == TIMEOUT_LIM) begin
          res_valid_d   = 1'b1;
          res_count_d   = '1;
          res_timeout_d = 1'b1;
          state_d       = GUARD;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end

      // Enable is only consulted here, so a slot in flight always finishes.
      GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          sel_d   = sel_q + SEL_ONE;
          cnt_d   = '0;
          state_d = bus.enable ? TRIG : IDLE;
        end else begin
          cnt_d = cnt_q + CTR_ONE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      trig_q        <= 1'b0;
      res_valid_q   <= 1'b0;
      res_idx_q     <= '0;
      res_count_q   <= '0;
      res_timeout_q <= 1'b0;
      scan_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      trig_q        <= (state_d == TRIG);
      res_valid_q   <= res_valid_d;
      res_count_q   <= res_count_d;
      res_timeout_q <= res_timeout_d;
      scan_done_q   <= res_valid_d && (sel_q == SEL_LAST);
      if (res_valid_d) begin
        res_idx_q <= sel_q;
      end
    end
  end

  assign bus.sensor_sel     = sel_q;
  assign bus.trig           = trig_q;
  assign bus.result_valid   = res_valid_q;
  assign bus.result_idx     = res_idx_q;
  assign bus.result_count   = res_count_q;
  assign bus.result_timeout = res_timeout_q;
  assign bus.scan_done      = scan_done_q;

endmodule

// File: tb/tb_ultrasonic_scan_sequencer.sv
// Scoreboard bench: slot stimulus pushes expected results, a monitor pops them on result_valid.
module tb_ultrasonic_scan_sequencer;
  import ultrasonic_pkg::*;

  localparam int TRIG_C  = 4;
  localparam int TMO_C   = 50;
  localparam int GUARD_C = 8;
  localparam int CW      = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  ultrasonic_scan_sequencer_if #(.CNT_W(CW)) bus ();

  ultrasonic_scan_sequencer #(
    .TRIG_CYCLES    (TRIG_C),
    .TIMEOUT_CYCLES (TMO_C),
    .GUARD_CYCLES   (GUARD_C),
    .CNT_W          (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int width;
    bit timeout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   model_idx = 0;
  int   pulse_from[8];
  int   pulse_until[8];

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_near(input string name, input int act, input int req, input int tol);
    n_checks++;
    if (act < req - tol || act > req + tol) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d +/- %0d (t=%0t)", name, act, req, tol, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Echo lines are a pure function of the scheduled per-channel pulse windows.
  always @(negedge clk) begin
    for (int ch = 0; ch < 8; ch++) begin
      bus.echo[ch] = (cyc >= pulse_from[ch]) && (cyc < pulse_until[ch]);
    end
  end

  always @(negedge clk) begin
    if (bus.result_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result_idx", int'(bus.result_idx), mon_e.idx);
        check("result_timeout", int'(bus.result_timeout), int'(mon_e.timeout));
        if (mon_e.timeout) check("result_count_timeout", int'(bus.result_count), 255);
        else               check_near("result_count", int'(bus.result_count), mon_e.width, 1);
        check("scan_done", int'(bus.scan_done), int'(mon_e.idx == 7));
      end
    end else if (bus.scan_done) begin
      check("scan_done_without_result", 1, 0);
    end
  end

  // Waits for the next trigger, checks select and pulse length, returns on the first WAIT_RISE cycle.
  task automatic start_slot();
    int n;
    int hi;
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.trig && n < 400);
    check("trig_rise_seen", int'(bus.trig), 1);
    check("sensor_sel", int'(bus.sensor_sel), model_idx);
    while (bus.trig && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    check("trig_width", hi, TRIG_C);
  endtask

  // w == 0 means no echo; nch < 0 means no crosstalk pulse.
  task automatic run_slot(input int dly, input int w, input int nch, input int ndly, input int nw);
    exp_t e;
    start_slot();
    e.idx     = model_idx;
    e.width   = w;
    e.timeout = (w == 0) || (w > TMO_C);
    exp_q.push_back(e);
    if (w > 0) begin
      pulse_from[model_idx]  = cyc + dly;
      pulse_until[model_idx] = cyc + dly + w;
    end
    if (nch >= 0) begin
      pulse_from[nch]  = cyc + ndly;
      pulse_until[nch] = cyc + ndly + nw;
    end
    model_idx = (model_idx + 1) % 8;
  endtask

  task automatic random_slot(input bit allow_none);
    int w;
    int nch;
    w   = (allow_none && $urandom_range(5, 0) == 0) ? 0 : int'($urandom_range(45, 1));
    nch = ($urandom_range(1, 0) == 1) ? (model_idx + 2 + int'($urandom_range(5, 0))) % 8 : -1;
    run_slot(int'($urandom_range(30, 1)), w, nch, int'($urandom_range(5, 1)), int'($urandom_range(15, 3)));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sensor_sel"}, int'(bus.sensor_sel), 0);
    check({tag, "_trig"}, int'(bus.trig), 0);
    check({tag, "_result_valid"}, int'(bus.result_valid), 0);
    check({tag, "_result_idx"}, int'(bus.result_idx), 0);
    check({tag, "_result_count"}, int'(bus.result_count), 0);
    check({tag, "_result_timeout"}, int'(bus.result_timeout), 0);
    check({tag, "_scan_done"}, int'(bus.scan_done), 0);
  endtask

  initial begin
    int n;
    int highs;
    reset      = 1'b1;
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    bus.enable = 1'b1;

    run_slot(10, 20, -1, 0, 0);

    run_slot(1, 0, -1, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.result_valid && n < 200);
    check("timeout_latency", n, TMO_C);

    run_slot(5, 15, 5, 5, 20);

    run_slot(2, 200, -1, 0, 0);
    bus.enable = 1'b0;
    repeat (240) @(negedge clk);
    check("idle_after_stuck_trig", int'(bus.trig), 0);
    check("idle_after_stuck_sel", int'(bus.sensor_sel), model_idx);
    bus.enable = 1'b1;

    while (model_idx != 0) random_slot(1'b0);
    for (int i = 0; i < 8; i++) run_slot(int'($urandom_range(20, 1)), 5 * (i + 1), -1, 0, 0);
    for (int i = 0; i < 12; i++) random_slot(1'b1);

    run_slot(3, 30, -1, 0, 0);
    repeat (15) @(negedge clk);
    bus.enable = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("results_drained", exp_q.size(), 0);
    repeat (GUARD_C + 5) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.trig) highs++;
    end
    check("idle_trig_low", highs, 0);
    check("idle_sel_advanced", int'(bus.sensor_sel), model_idx);

    bus.enable = 1'b1;
    start_slot();
    pulse_from[model_idx]  = cyc + 3;
    pulse_until[model_idx] = cyc + 33;
    repeat (15) @(negedge clk);
    reset      = 1'b1;
    bus.enable = 1'b0;
    @(negedge clk);
    check_outputs_zero("midmeasure_reset");
    for (int ch = 0; ch < 8; ch++) pulse_until[ch] = 0;
    repeat (3) @(negedge clk);
    reset     = 1'b0;
    model_idx = 0;
    repeat (60) @(negedge clk);
    check("post_reset_sel", int'(bus.sensor_sel), 0);
    check("post_reset_trig", int'(bus.trig), 0);

    check("queue_empty_end", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
